// File: rtl/ex_wb_arbiter.sv
// Write-back arbiter: merges ALU and LSU results onto the single register-file
// write port, with an ALU result FIFO, bounded starvation and forwarding lookup.
module ex_wb_arbiter #(
  parameter int XLEN       = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          alu_valid,
  output logic                          alu_ready,
  input  logic [4:0]                    alu_rd,
  input  logic [XLEN-1:0]               alu_data,
  input  logic                          lsu_valid,
  output logic                          lsu_ready,
  input  logic [4:0]                    lsu_rd,
  input  logic [XLEN-1:0]               lsu_data,
  output logic                          wb_en,
  output logic [4:0]                    wb_rd,
  output logic [XLEN-1:0]               wb_data,
  input  logic [4:0]                    fwd_rs1,
  input  logic [4:0]                    fwd_rs2,
  output logic                          fwd_rs1_hit,
  output logic [XLEN-1:0]               fwd_rs1_data,
  output logic                          fwd_rs2_hit,
  output logic [XLEN-1:0]               fwd_rs2_data,
  output logic [$clog2(FIFO_DEPTH):0]   pend_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [4:0]      fifo_rd   [FIFO_DEPTH];
  logic [XLEN-1:0] fifo_data [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic [SW-1:0]   starve_cnt;

  logic            full, empty, alu_acc, alu_src, alu_force;
  logic            lsu_win, alu_win, push, pop;
  logic [4:0]      src_rd;
  logic [XLEN-1:0] src_data;

  // Handshake: a result transfers on a cycle where valid and ready are both
  // high; ready never depends on a same-cycle pop.
  always_comb begin
    full      = (count == CW'(FIFO_DEPTH));
    empty     = (count == '0);
    alu_ready = !full;
    alu_acc   = alu_valid && !full && (alu_rd != 5'd0);
    alu_src   = !empty || alu_acc;
    alu_force = (starve_cnt == SW'(STARVE_MAX)) && alu_src;
    lsu_ready = !alu_force;
    lsu_win   = lsu_valid && !alu_force;
    alu_win   = alu_src && !lsu_win;
    pop       = alu_win && !empty;
    // An empty FIFO lets a winning ALU result fall straight through.
    push      = alu_acc && !(alu_win && empty);
    src_rd    = empty ? alu_rd   : fifo_rd[rd_ptr];
    src_data  = empty ? alu_data : fifo_data[rd_ptr];
    pend_count = count;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_en      <= 1'b0;
      wb_rd      <= 5'd0;
      wb_data    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      starve_cnt <= '0;
    end else begin
      if (lsu_win) begin
        wb_en   <= (lsu_rd != 5'd0);
        wb_rd   <= lsu_rd;
        wb_data <= lsu_data;
      end else if (alu_win) begin
        wb_en   <= 1'b1;
        wb_rd   <= src_rd;
        wb_data <= src_data;
      end else begin
        wb_en   <= 1'b0;
      end
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (alu_src && lsu_win)
        starve_cnt <= (starve_cnt == SW'(STARVE_MAX)) ? starve_cnt : starve_cnt + SW'(1);
      else
        starve_cnt <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wr_ptr]   <= alu_rd;
      fifo_data[wr_ptr] <= alu_data;
    end
  end

  // Lowest priority first (wb register, then oldest entry) so the newest match
  // is the last to overwrite.
  function automatic logic [XLEN:0] lookup(input logic [4:0] rs);
    logic [XLEN:0] r;
    logic [AW-1:0] idx;
    r = '0;
    if (rs != 5'd0) begin
      if (wb_en && wb_rd == rs) r = {1'b1, wb_data};
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        idx = rd_ptr + AW'(i);
        if (CW'(i) < count && fifo_rd[idx] == rs) r = {1'b1, fifo_data[idx]};
      end
    end
    return r;
  endfunction

  always_comb begin
    {fwd_rs1_hit, fwd_rs1_data} = lookup(fwd_rs1);
    {fwd_rs2_hit, fwd_rs2_data} = lookup(fwd_rs2);
  end

endmodule

// File: tb/tb_ex_wb_arbiter.sv
// Bench for ex_wb_arbiter: directed scenarios plus random traffic, checked
// against a queue-based model of pending ALU results.
module tb_ex_wb_arbiter;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int SMAX  = 3;

  logic clk = 1'b0;
  logic rst;
  logic alu_valid, alu_ready, lsu_valid, lsu_ready, wb_en;
  logic [4:0] alu_rd, lsu_rd, wb_rd, fwd_rs1, fwd_rs2;
  logic [XLEN-1:0] alu_data, lsu_data, wb_data, fwd_rs1_data, fwd_rs2_data;
  logic fwd_rs1_hit, fwd_rs2_hit;
  logic [2:0] pend_count;

  int total = 0;
  int bad = 0;

  // Model: pending ALU results as {rd, data}, oldest at the front.
  logic [36:0] exp_q[$];
  int          m_starve;
  logic        m_en;
  logic [4:0]  m_rd;
  logic [31:0] m_data;

  always #5 clk = ~clk;

  ex_wb_arbiter #(.XLEN(XLEN), .FIFO_DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2),
    .fwd_rs1_hit(fwd_rs1_hit), .fwd_rs1_data(fwd_rs1_data),
    .fwd_rs2_hit(fwd_rs2_hit), .fwd_rs2_data(fwd_rs2_data),
    .pend_count(pend_count)
  );

  task automatic model_reset();
    exp_q.delete();
    m_starve = 0;
    m_en = 1'b0;
    m_rd = 5'd0;
    m_data = '0;
  endtask

  task automatic clear_inputs();
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
    fwd_rs1 = 0; fwd_rs2 = 0;
  endtask

  function automatic logic [32:0] model_fwd(input logic [4:0] rs);
    if (rs == 5'd0) return '0;
    for (int i = exp_q.size() - 1; i >= 0; i--)
      if (exp_q[i][36:32] == rs) return {1'b1, exp_q[i][31:0]};
    if (m_en && m_rd == rs) return {1'b1, m_data};
    return '0;
  endfunction

  // One clock with the inputs currently driven: checks handshake/forwarding
  // before the edge and the write port after it, advancing the model.
  task automatic cycle();
    logic [32:0] f1, f2;
    bit acc, src, starved, lsu_takes, from_q;
    #1;
    acc = alu_valid && exp_q.size() < DEPTH && alu_rd != 0;
    src = exp_q.size() > 0 || acc;
    starved = (m_starve == SMAX) && src;
    lsu_takes = lsu_valid && !starved;
    f1 = model_fwd(fwd_rs1);
    f2 = model_fwd(fwd_rs2);
    total++;
    if (alu_ready !== (exp_q.size() < DEPTH)) begin
      bad++; $display("FAIL alu_ready got=%0b want=%0b", alu_ready, exp_q.size() < DEPTH);
    end
    total++;
    if (lsu_ready !== !starved) begin
      bad++; $display("FAIL lsu_ready got=%0b want=%0b", lsu_ready, !starved);
    end
    total++;
    if ({fwd_rs1_hit, fwd_rs1_data} !== f1) begin
      bad++; $display("FAIL fwd_rs1 rs=%0d got=%0b/%h want=%0b/%h", fwd_rs1,
                      fwd_rs1_hit, fwd_rs1_data, f1[32], f1[31:0]);
    end
    total++;
    if ({fwd_rs2_hit, fwd_rs2_data} !== f2) begin
      bad++; $display("FAIL fwd_rs2 rs=%0d got=%0b/%h want=%0b/%h", fwd_rs2,
                      fwd_rs2_hit, fwd_rs2_data, f2[32], f2[31:0]);
    end
    from_q = 0;
    if (lsu_takes) begin
      m_en = (lsu_rd != 0); m_rd = lsu_rd; m_data = lsu_data;
    end else if (src) begin
      m_en = 1'b1;
      if (exp_q.size() > 0) begin
        {m_rd, m_data} = exp_q.pop_front();
        from_q = 1;
      end else begin
        m_rd = alu_rd; m_data = alu_data;
      end
    end else begin
      m_en = 1'b0;
    end
    if (acc && (lsu_takes || from_q)) exp_q.push_back({alu_rd, alu_data});
    m_starve = (src && lsu_takes) ? ((m_starve < SMAX) ? m_starve + 1 : SMAX) : 0;
    @(posedge clk);
    #1;
    total++;
    if (wb_en !== m_en) begin
      bad++; $display("FAIL wb_en got=%0b want=%0b", wb_en, m_en);
    end
    if (m_en) begin
      total++;
      if (wb_rd !== m_rd || wb_data !== m_data) begin
        bad++; $display("FAIL wb_write got=r%0d/%h want=r%0d/%h", wb_rd, wb_data, m_rd, m_data);
      end
    end
    total++;
    if (pend_count !== 3'(exp_q.size())) begin
      bad++; $display("FAIL pend_count got=%0d want=%0d", pend_count, exp_q.size());
    end
  endtask

  task automatic drain();
    clear_inputs();
    for (int i = 0; i < 12; i++) cycle();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    model_reset();
    #3;
    total++;
    if (wb_en !== 1'b0 || wb_rd !== 5'd0 || wb_data !== '0 || pend_count !== 3'd0) begin
      bad++; $display("FAIL reset_state got en=%0b rd=%0d data=%h cnt=%0d want 0/0/0/0",
                      wb_en, wb_rd, wb_data, pend_count);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_alu_only();
    alu_valid = 1; alu_rd = 5; alu_data = 32'h1234;
    cycle();
    total++;
    if (wb_en !== 1'b1 || wb_rd !== 5'd5 || wb_data !== 32'h1234 || pend_count !== 3'd0) begin
      bad++; $display("FAIL alu_only got en=%0b rd=%0d data=%h cnt=%0d want 1/5/1234/0",
                      wb_en, wb_rd, wb_data, pend_count);
    end
    drain();
  endtask

  task automatic test_same_cycle();
    alu_valid = 1; alu_rd = 3; alu_data = 32'hA;
    lsu_valid = 1; lsu_rd = 4; lsu_data = 32'hB;
    cycle();
    total++;
    if (wb_rd !== 5'd4 || wb_data !== 32'hB || pend_count !== 3'd1) begin
      bad++; $display("FAIL same_cycle_lsu got rd=%0d data=%h cnt=%0d want 4/b/1",
                      wb_rd, wb_data, pend_count);
    end
    clear_inputs();
    cycle();
    total++;
    if (wb_en !== 1'b1 || wb_rd !== 5'd3 || wb_data !== 32'hA || pend_count !== 3'd0) begin
      bad++; $display("FAIL same_cycle_alu got en=%0b rd=%0d data=%h cnt=%0d want 1/3/a/0",
                      wb_en, wb_rd, wb_data, pend_count);
    end
    drain();
  endtask

  task automatic test_starve();
    alu_valid = 1; alu_rd = 9; alu_data = 32'h99;
    lsu_valid = 1; lsu_rd = 10; lsu_data = 32'h100;
    cycle();
    alu_valid = 0;
    for (int i = 1; i < 3; i++) begin
      lsu_rd = 5'(10 + i); lsu_data = 32'h100 + i;
      cycle();
    end
    lsu_rd = 13; lsu_data = 32'h103;
    #1;
    total++;
    if (lsu_ready !== 1'b0) begin
      bad++; $display("FAIL starve_lsu_ready got=%0b want=0", lsu_ready);
    end
    cycle();
    total++;
    if (wb_rd !== 5'd9 || wb_data !== 32'h99) begin
      bad++; $display("FAIL starve_alu_write got=r%0d/%h want=r9/99", wb_rd, wb_data);
    end
    cycle();
    total++;
    if (wb_rd !== 5'd13) begin
      bad++; $display("FAIL starve_lsu_resume got=r%0d want=r13", wb_rd);
    end
    drain();
  endtask

  task automatic test_fill();
    int n;
    lsu_valid = 1; alu_valid = 1;
    n = 0;
    while (pend_count !== 3'd4 && n < 20) begin
      alu_rd = 5'(1 + (n % 7)); alu_data = $urandom;
      lsu_rd = 20; lsu_data = $urandom;
      cycle();
      n++;
    end
    total++;
    if (pend_count !== 3'd4 || alu_ready !== 1'b0) begin
      bad++; $display("FAIL fill_full got cnt=%0d ready=%0b want 4/0", pend_count, alu_ready);
    end
    alu_valid = 0;
    n = 0;
    while (pend_count === 3'd4 && n < 10) begin
      lsu_data = $urandom;
      cycle();
      n++;
    end
    total++;
    if (alu_ready !== 1'b1 || pend_count !== 3'd3) begin
      bad++; $display("FAIL fill_release got ready=%0b cnt=%0d want 1/3", alu_ready, pend_count);
    end
    drain();
  endtask

  task automatic test_forward();
    lsu_valid = 1; lsu_rd = 20; lsu_data = 32'h55;
    alu_valid = 1; alu_rd = 7; alu_data = 1;
    cycle();
    alu_data = 2;
    cycle();
    clear_inputs();
    fwd_rs1 = 7; fwd_rs2 = 0;
    #1;
    total++;
    if (fwd_rs1_hit !== 1'b1 || fwd_rs1_data !== 32'd2) begin
      bad++; $display("FAIL fwd_newest got=%0b/%h want=1/2", fwd_rs1_hit, fwd_rs1_data);
    end
    total++;
    if (fwd_rs2_hit !== 1'b0 || fwd_rs2_data !== '0) begin
      bad++; $display("FAIL fwd_r0 got=%0b/%h want=0/0", fwd_rs2_hit, fwd_rs2_data);
    end
    alu_valid = 1; alu_rd = 0; alu_data = 32'hDEAD;
    cycle();
    total++;
    if (pend_count !== 3'd1 || wb_rd !== 5'd7 || wb_data !== 32'd1) begin
      bad++; $display("FAIL alu_rd0 got cnt=%0d r%0d/%h want 1/r7/1", pend_count, wb_rd, wb_data);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    lsu_valid = 1; lsu_rd = 20; alu_valid = 1;
    for (int i = 0; i < 3; i++) begin
      alu_rd = 5'(11 + i); alu_data = $urandom; lsu_data = $urandom;
      cycle();
    end
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (wb_en !== 1'b0 || pend_count !== 3'd0) begin
      bad++; $display("FAIL reset_mid got en=%0b cnt=%0d want 0/0", wb_en, pend_count);
    end
    model_reset();
    clear_inputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) cycle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      alu_valid = ($urandom_range(0, 3) != 0);
      alu_rd = 5'($urandom_range(0, 7));
      alu_data = $urandom;
      lsu_valid = ($urandom_range(0, 2) != 0);
      lsu_rd = 5'($urandom_range(0, 7));
      lsu_data = $urandom;
      fwd_rs1 = 5'($urandom_range(0, 7));
      fwd_rs2 = 5'($urandom_range(0, 7));
      cycle();
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_alu_only();
    test_same_cycle();
    test_starve();
    test_fill();
    test_forward();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
